mul_share_arbiter: RTL and testbench

- Sequences the shared shift-add multiplier (its Control + datapath) and shares it between two requesters, e.g. the MIPS EX-stage MULT path and a second client.
- Arbitrates round-robin and latches the winner's operands onto the multiplier inputs.
- Issues the one-cycle start, waits for the multiplier's Done, and returns the product tagged to the owning requester.
- A watchdog aborts an operation whose Done never arrives.

---
 rtl/mul_share_arbiter_if.sv | 34 +++
 rtl/mul_share_arbiter.sv | 95 +++++++++
 tb/tb_mul_share_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_arbiter_if.sv
// Request, response and multiplier-side signals of the shared multiplier arbiter.
// The arbiter connects through the slave modport; requesters and multiplier use master.
interface mul_share_arbiter_if #(
  parameter int N = 16
);
  logic           Req0;
  logic [N-1:0]   A0;
  logic [N-1:0]   B0;
  logic           Req1;
  logic [N-1:0]   A1;
  logic [N-1:0]   B1;
  logic           Gnt0;
  logic           Gnt1;
  logic           Vld0;
  logic           Vld1;
  logic [2*N-1:0] Res;
  logic           Err;
  logic           Busy;
  logic           Mul_St;
  logic [N-1:0]   Mul_A;
  logic [N-1:0]   Mul_B;
  logic           Mul_Done;
  logic [2*N-1:0] Mul_P;

  modport slave (
    input  Req0, A0, B0, Req1, A1, B1, Mul_Done, Mul_P,
    output Gnt0, Gnt1, Vld0, Vld1, Res, Err, Busy, Mul_St, Mul_A, Mul_B
  );

  modport master (
    output Req0, A0, B0, Req1, A1, B1, Mul_Done, Mul_P,
    input  Gnt0, Gnt1, Vld0, Vld1, Res, Err, Busy, Mul_St, Mul_A, Mul_B
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one shift-add multiplier between two requesters,
// with start/done sequencing, owner-tagged results and a Done watchdog.
module mul_share_arbiter #(
  parameter int N       = 16,
  parameter int TIMEOUT = 64
) (
  input logic                  Clk,
  input logic                  Rst_n,
  mul_share_arbiter_if.slave   bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             win;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win = 1'b0;
    if (bus.Req0 && bus.Req1) win = ~last;
    else                      win = bus.Req1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;
      cnt        <= '0;
      bus.Gnt0   <= 1'b0;
      bus.Gnt1   <= 1'b0;
      bus.Vld0   <= 1'b0;
      bus.Vld1   <= 1'b0;
      bus.Err    <= 1'b0;
      bus.Busy   <= 1'b0;
      bus.Mul_St <= 1'b0;
      bus.Mul_A  <= '0;
      bus.Mul_B  <= '0;
      bus.Res    <= '0;
    end else begin
      bus.Gnt0   <= 1'b0;
      bus.Gnt1   <= 1'b0;
      bus.Vld0   <= 1'b0;
      bus.Vld1   <= 1'b0;
      bus.Err    <= 1'b0;
      bus.Mul_St <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Req0 || bus.Req1) begin
            state      <= ISSUE;
            owner      <= win;
            bus.Mul_A  <= win ? bus.A1 : bus.A0;
            bus.Mul_B  <= win ? bus.B1 : bus.B0;
            bus.Gnt0   <= ~win;
            bus.Gnt1   <= win;
            bus.Mul_St <= 1'b1;
            bus.Busy   <= 1'b1;
          end
        end
        // A Done seen during ISSUE is left over from the multiplier's previous run.
        ISSUE: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (bus.Mul_Done) begin
            bus.Res  <= bus.Mul_P;
            bus.Vld0 <= ~owner;
            bus.Vld1 <= owner;
            state    <= RESP;
          end else if (cnt == CNT_LAST) begin
            bus.Res  <= '0;
            bus.Err  <= 1'b1;
            bus.Vld0 <= ~owner;
            bus.Vld1 <= owner;
            state    <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          last     <= owner;
          bus.Busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized bench for mul_share_arbiter: behavioural multiplier plus a
// transaction-level reference model of arbitration, latency and results.
module tb_mul_share_arbiter;
  localparam int N       = 16;
  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.N(N)) b();

  mul_share_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state (transaction level)
  bit             m_busy = 1'b0;
  bit             m_free = 1'b0;
  bit             m_owner = 1'b0;
  bit             m_last = 1'b1;
  bit             m_err = 1'b0;
  logic [2*N-1:0] m_res = '0;
  logic [2*N-1:0] m_exp_res = '0;
  int             m_vld_cyc = -1;

  // requester behaviour
  int rem0 = 0;
  int rem1 = 0;
  bit rnd_ops = 1'b0;

  // behavioural multiplier
  int             mul_lat = 8;
  int             mrem = 0;
  bit             mul_never = 1'b0;
  bit             stale_en = 1'b0;
  logic [2*N-1:0] mprod = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    bit p_idle, p_r0, p_r1, p_rst, exp_g, exp_v, win;
    logic [N-1:0] pa0, pb0, pa1, pb1;
    p_idle = !m_busy;
    p_r0 = b.Req0;  p_r1 = b.Req1;  p_rst = rst_n;
    pa0 = b.A0;  pb0 = b.B0;  pa1 = b.A1;  pb1 = b.B1;
    @(posedge clk);
    #1;
    cyc++;
    if (m_free) begin
      m_busy = 1'b0;
      m_free = 1'b0;
    end
    if (!p_rst) begin
      m_busy = 1'b0;  m_free = 1'b0;  m_last = 1'b1;  m_res = '0;  m_vld_cyc = -1;
      check("rst_gnt", 64'({b.Gnt1, b.Gnt0}), 64'(0));
      check("rst_vld", 64'({b.Vld1, b.Vld0}), 64'(0));
      check("rst_err_busy_st", 64'({b.Err, b.Busy, b.Mul_St}), 64'(0));
      check("rst_mul_ab", 64'({b.Mul_A, b.Mul_B}), 64'(0));
      check("rst_res", 64'(b.Res), 64'(0));
    end else begin
      exp_g = p_idle && (p_r0 || p_r1);
      if (exp_g || b.Gnt0 || b.Gnt1 || b.Mul_St) begin
        check("gnt_seen", 64'(b.Gnt0 | b.Gnt1), 64'(exp_g));
        check("mul_st", 64'(b.Mul_St), 64'(exp_g));
        if (exp_g) begin
          win = (p_r0 && p_r1) ? !m_last : p_r1;
          check("gnt_who", 64'({b.Gnt1, b.Gnt0}), win ? 64'(2) : 64'(1));
          check("mul_ab", 64'({b.Mul_A, b.Mul_B}), win ? 64'({pa1, pb1}) : 64'({pa0, pb0}));
          m_busy  = 1'b1;
          m_owner = win;
          if (mul_never || mul_lat > TIMEOUT) begin
            m_exp_res = '0;
            m_err     = 1'b1;
            m_vld_cyc = cyc + TIMEOUT + 1;
          end else begin
            m_exp_res = win ? (2*N)'(pa1) * (2*N)'(pb1) : (2*N)'(pa0) * (2*N)'(pb0);
            m_err     = 1'b0;
            m_vld_cyc = cyc + mul_lat + 1;
          end
        end
      end
      exp_v = m_busy && (cyc == m_vld_cyc);
      if (exp_v || b.Vld0 || b.Vld1) begin
        check("vld_seen", 64'(b.Vld0 | b.Vld1), 64'(exp_v));
        if (exp_v) begin
          check("vld_who", 64'({b.Vld1, b.Vld0}), m_owner ? 64'(2) : 64'(1));
          check("res", 64'(b.Res), 64'(m_exp_res));
          check("err", 64'(b.Err), 64'(m_err));
          m_res = m_exp_res;
        end
      end else begin
        check("res_hold", 64'(b.Res), 64'(m_res));
        check("err_idle", 64'(b.Err), 64'(0));
      end
      check("busy", 64'(b.Busy), 64'(m_busy));
      if (exp_v) begin
        m_last = m_owner;
        m_free = 1'b1;
      end
      // requesters: keep Req high only to issue another operation
      if (b.Gnt0) begin
        rem0--;
        if (rem0 > 0) begin
          if (rnd_ops) begin b.A0 = N'($urandom); b.B0 = N'($urandom); end
        end else b.Req0 = 1'b0;
      end
      if (b.Gnt1) begin
        rem1--;
        if (rem1 > 0) begin
          if (rnd_ops) begin b.A1 = N'($urandom); b.B1 = N'($urandom); end
        end else b.Req1 = 1'b0;
      end
      if (!b.Req0 && rem0 > 0 && $urandom_range(0, 2) == 0) begin
        b.Req0 = 1'b1;  b.A0 = N'($urandom);  b.B0 = N'($urandom);
      end
      if (!b.Req1 && rem1 > 0 && $urandom_range(0, 2) == 0) begin
        b.Req1 = 1'b1;  b.A1 = N'($urandom);  b.B1 = N'($urandom);
      end
    end
    // multiplier: Done pulses mul_lat cycles after the cycle St is seen high
    if (b.Mul_St) begin
      mprod      = (2*N)'(b.Mul_A) * (2*N)'(b.Mul_B);
      mrem       = mul_lat;
      b.Mul_Done = stale_en;
      b.Mul_P    = (2*N)'($urandom);
    end else if (mrem > 0) begin
      mrem--;
      if (mrem == 0 && !mul_never) begin
        b.Mul_Done = 1'b1;
        b.Mul_P    = mprod;
      end else begin
        b.Mul_Done = 1'b0;
        b.Mul_P    = (2*N)'($urandom);
      end
    end else begin
      b.Mul_Done = 1'b0;
    end
  endtask

  task automatic run(input int max_cyc);
    int k = 0;
    while ((rem0 > 0 || rem1 > 0 || m_busy) && k < max_cyc) begin
      tick();
      k++;
    end
    check("run_complete", 64'({rem0 != 0, rem1 != 0, m_busy}), 64'(0));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    b.Req0 = 1'b0;  b.Req1 = 1'b0;  rem0 = 0;  rem1 = 0;
    repeat (n) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic single(input bit who, input logic [N-1:0] a, input logic [N-1:0] bb);
    if (who) begin b.A1 = a; b.B1 = bb; b.Req1 = 1'b1; rem1 = 1; end
    else     begin b.A0 = a; b.B0 = bb; b.Req0 = 1'b1; rem0 = 1; end
    run(400);
  endtask

  initial begin
    b.Req0 = 1'b0;  b.Req1 = 1'b0;
    b.A0 = '0;  b.B0 = '0;  b.A1 = '0;  b.B1 = '0;
    b.Mul_Done = 1'b0;  b.Mul_P = '0;

    do_reset(2);

    mul_lat = 8;
    single(1'b0, 16'd3, 16'd5);
    tick();

    // both held continuously with fixed operands: grants alternate 0,1,0,1
    do_reset(1);
    b.A0 = 16'd2;  b.B0 = 16'd7;  b.A1 = 16'd4;  b.B1 = 16'd9;
    b.Req0 = 1'b1; b.Req1 = 1'b1; rem0 = 2; rem1 = 2;
    run(400);

    single(1'b1, 16'hFFFF, 16'hFFFF);

    // watchdog abort, then a normal operation
    mul_never = 1'b1;
    single(1'b0, 16'd21, 16'd3);
    mul_never = 1'b0;
    single(1'b0, 16'd21, 16'd3);

    // Done on the timeout edge wins; one cycle later is too late
    mul_lat = TIMEOUT;
    single(1'b1, 16'd1234, 16'd77);
    mul_lat = TIMEOUT + 1;
    single(1'b1, 16'd1234, 16'd77);
    repeat (3) tick();

    mul_lat = 6;  stale_en = 1'b1;
    single(1'b0, 16'd300, 16'd400);
    stale_en = 1'b0;

    rnd_ops = 1'b1;
    for (int r = 0; r < 30; r++) begin
      mul_lat   = $urandom_range(1, 12);
      stale_en  = ($urandom_range(0, 3) == 0);
      mul_never = ($urandom_range(0, 9) == 0);
      rem0 = $urandom_range(0, 3);
      rem1 = $urandom_range(0, 3);
      run(1500);
    end
    rnd_ops = 1'b0;  stale_en = 1'b0;  mul_never = 1'b0;

    // reset in WAIT, then a late Done must be ignored
    mul_lat = 20;
    b.A0 = 16'd11;  b.B0 = 16'd13;  b.Req0 = 1'b1;  rem0 = 1;
    repeat (6) tick();
    check("mid_busy", 64'(b.Busy), 64'(1));
    rst_n = 1'b0;  b.Req0 = 1'b0;  rem0 = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (25) tick();
    mul_lat = 5;
    b.A0 = 16'd6;  b.B0 = 16'd7;  b.A1 = 16'd8;  b.B1 = 16'd9;
    b.Req0 = 1'b1; b.Req1 = 1'b1; rem0 = 1; rem1 = 1;
    run(400);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "time limit");
  end
endmodule
